// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sys_sdram controller port between NREQ requesters.
// Registered outputs; a watchdog aborts transactions the controller never completes.
module sdram_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [32*NREQ-1:0]   req_addr_i,
    input  logic [32*NREQ-1:0]   req_wdata_i,
    input  logic [4*NREQ-1:0]    req_wstrb_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [31:0]          req_rdata_o,
    output logic                 req_err_o,
    output logic                 m_valid_o,
    output logic [31:0]          m_addr_o,
    output logic [31:0]          m_wdata_o,
    output logic [3:0]           m_wstrb_o,
    input  logic                 m_ready_i,
    input  logic [31:0]          m_rdata_i,
    output logic [2:0]           grant_o
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      last_grant_q, last_grant_d;
    logic [2:0]      grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            m_valid_d;
    logic [31:0]     m_addr_d, m_wdata_d;
    logic [3:0]      m_wstrb_d;
    logic [NREQ-1:0] ready_d;
    logic [31:0]     rdata_d;
    logic            err_d;

    logic [2:0]      win;
    logic            found;

    // Search starts one past the last owner so every requester gets its turn.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_grant_q) + i) % NREQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_o;
        cnt_d        = cnt_q;
        m_valid_d    = m_valid_o;
        m_addr_d     = m_addr_o;
        m_wdata_d    = m_wdata_o;
        m_wstrb_d    = m_wstrb_o;
        ready_d      = '0;
        rdata_d      = req_rdata_o;
        err_d        = req_err_o;
        case (state_q)
            IDLE: begin
                if (found) begin
                    m_valid_d = 1'b1;
                    m_addr_d  = req_addr_i[32*int'(win) +: 32];
                    m_wdata_d = req_wdata_i[32*int'(win) +: 32];
                    m_wstrb_d = req_wstrb_i[4*int'(win) +: 4];
                    grant_d   = win;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Terminal count sits one past TIMEOUT-1 so the error pulse lands
                // TIMEOUT+1 cycles after m_valid_o rises; m_ready_i takes priority.
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    rdata_d   = m_rdata_i;
                    err_d     = 1'b0;
                    ready_d   = NREQ'(1) << grant_o;
                    state_d   = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
                    m_valid_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    ready_d   = NREQ'(1) << grant_o;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                last_grant_d = grant_o;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= 3'(NREQ - 1);
            grant_o      <= '0;
            cnt_q        <= '0;
            m_valid_o    <= 1'b0;
            m_addr_o     <= '0;
            m_wdata_o    <= '0;
            m_wstrb_o    <= '0;
            req_ready_o  <= '0;
            req_rdata_o  <= '0;
            req_err_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_o      <= grant_d;
            cnt_q        <= cnt_d;
            m_valid_o    <= m_valid_d;
            m_addr_o     <= m_addr_d;
            m_wdata_o    <= m_wdata_d;
            m_wstrb_o    <= m_wstrb_d;
            req_ready_o  <= ready_d;
            req_rdata_o  <= rdata_d;
            req_err_o    <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter (NREQ=3, TIMEOUT=16).
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [95:0] req_addr = '0;
    logic [95:0] req_wdata = '0;
    logic [11:0] req_wstrb = '0;
    logic [2:0]  req_ready;
    logic [31:0] req_rdata;
    logic        req_err;
    logic        m_valid;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [2:0]  grant;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_arbiter #(.NREQ(3), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .req_ready_o(req_ready), .req_rdata_o(req_rdata), .req_err_o(req_err),
        .m_valid_o(m_valid), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_wstrb_o(m_wstrb), .m_ready_i(m_ready), .m_rdata_i(m_rdata),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int limit, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (req_ready == 3'b000 && cyc < limit);
        if (req_ready == 3'b000)
            check("ready_wait_expired", 32'(cyc), 32'(limit + 1));
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
        req_wstrb[4*i +: 4]   = s;
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc;
        int pulses;
        int order [6] = '{2, 0, 1, 2, 0, 1};

        // Reset state
        #1 rst_n = 1'b0;
        step();
        step();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_ready",   32'(req_ready), 32'd0);
        check("rst_grant",   32'(grant), 32'd0);
        check("rst_err",     32'(req_err), 32'd0);
        check("rst_m_addr",  m_addr, 32'd0);
        rst_n = 1'b1;
        step();

        // Requester 1 read, controller ready 4 cycles after grant
        set_req(1, 32'h0000_0100, 32'h0, 4'b0000);
        req_valid = 3'b010;
        step();
        check("a_m_valid", 32'(m_valid), 32'd1);
        check("a_m_addr",  m_addr, 32'h100);
        check("a_m_wstrb", 32'(m_wstrb), 32'd0);
        check("a_grant",   32'(grant), 32'd1);
        step(); step(); step();
        check("a_busy_no_ready", 32'(req_ready), 32'd0);
        m_ready = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        step();
        check("a_ready",   32'(req_ready), 32'b010);
        check("a_rdata",   req_rdata, 32'hDEAD_BEEF);
        check("a_err",     32'(req_err), 32'd0);
        check("a_m_valid_low", 32'(m_valid), 32'd0);
        req_valid = 3'b000;
        m_ready   = 1'b0;
        step();
        check("a_pulse_width", 32'(req_ready), 32'd0);

        // Fairness: all valid, controller always ready; last owner was 1
        set_req(0, 32'h1000, 32'h0, 4'b0000);
        set_req(1, 32'h2000, 32'h0, 4'b0000);
        set_req(2, 32'h3000, 32'h0, 4'b0000);
        m_rdata   = 32'hA5A5_0000;
        m_ready   = 1'b1;
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_ready(10, cyc);
            check("b_spacing", 32'(cyc), 32'd2);
            check("b_ready",   32'(req_ready), 32'(3'b001 << order[k]));
            check("b_grant",   32'(grant), 32'(order[k]));
            check("b_m_addr",  m_addr, 32'(32'h1000 * (order[k] + 1)));
            check("b_rdata",   req_rdata, 32'hA5A5_0000);
            if (k == 5) begin
                req_valid = 3'b000;
                m_ready   = 1'b0;
            end
            step();
            check("b_pulse_width", 32'(req_ready), 32'd0);
        end

        // Requester 2 write; payload held while requester drops and scrambles inputs
        set_req(2, 32'h0000_2000, 32'h1234_5678, 4'b0011);
        req_valid = 3'b100;
        step();
        check("c_m_valid", 32'(m_valid), 32'd1);
        check("c_grant",   32'(grant), 32'd2);
        check("c_m_wdata", m_wdata, 32'h1234_5678);
        check("c_m_wstrb", 32'(m_wstrb), 32'b0011);
        req_valid = 3'b000;
        set_req(2, 32'hFFFF_FFFF, 32'h0, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            step();
            check("c_hold_valid", 32'(m_valid), 32'd1);
            check("c_hold_addr",  m_addr, 32'h2000);
            check("c_hold_wdata", m_wdata, 32'h1234_5678);
            check("c_hold_wstrb", 32'(m_wstrb), 32'b0011);
        end
        m_ready = 1'b1;
        m_rdata = 32'h0000_0055;
        step();
        check("c_m_valid_drop", 32'(m_valid), 32'd0);
        check("c_ready",        32'(req_ready), 32'b100);
        m_ready = 1'b0;
        step();

        // Timeout: requester 0, controller silent; pulse 17 cycles after m_valid rises
        set_req(0, 32'h0000_0300, 32'h0, 4'b0000);
        req_valid = 3'b001;
        m_rdata   = 32'h7777_7777;
        step();
        check("d_m_valid", 32'(m_valid), 32'd1);
        check("d_grant",   32'(grant), 32'd0);
        wait_ready(40, cyc);
        check("d_latency", 32'(cyc), 32'd17);
        check("d_ready",   32'(req_ready), 32'b001);
        check("d_err",     32'(req_err), 32'd1);
        check("d_rdata",   req_rdata, 32'd0);
        check("d_m_valid_low", 32'(m_valid), 32'd0);
        req_valid = 3'b010;
        m_ready   = 1'b1;
        m_rdata   = 32'h0BAD_F00D;
        wait_ready(10, cyc);
        check("d_next_latency", 32'(cyc), 32'd3);
        check("d_next_ready",   32'(req_ready), 32'b010);
        check("d_next_err",     32'(req_err), 32'd0);
        check("d_next_rdata",   req_rdata, 32'h0BAD_F00D);
        req_valid = 3'b000;
        m_ready   = 1'b0;
        step();

        // m_ready arrives on the same edge as the terminal count
        req_valid = 3'b100;
        set_req(2, 32'h0000_4000, 32'h0, 4'b0000);
        step();
        check("e_grant", 32'(grant), 32'd2);
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (req_ready != 3'b000) pulses++;
        end
        check("e_no_early_pulse", 32'(pulses), 32'd0);
        m_ready = 1'b1;
        m_rdata = 32'hCAFE_F00D;
        step();
        check("e_ready", 32'(req_ready), 32'b100);
        check("e_err",   32'(req_err), 32'd0);
        check("e_rdata", req_rdata, 32'hCAFE_F00D);
        req_valid = 3'b000;
        m_ready   = 1'b0;
        step();

        // Reset while BUSY, then requester 0 has first priority
        req_valid = 3'b010;
        step();
        check("f_grant", 32'(grant), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("f_m_valid_async", 32'(m_valid), 32'd0);
        check("f_grant_async",   32'(grant), 32'd0);
        req_valid = 3'b111;
        m_ready   = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (req_ready != 3'b000) pulses++;
        end
        check("f_no_pulse", 32'(pulses), 32'd0);
        m_ready = 1'b0;
        rst_n   = 1'b1;
        step();
        check("f_post_grant",   32'(grant), 32'd0);
        check("f_post_m_valid", 32'(m_valid), 32'd1);
        check("f_post_m_addr",  m_addr, 32'h0000_0300);
        m_ready = 1'b1;
        m_rdata = 32'h0000_1234;
        step();
        check("f_post_ready", 32'(req_ready), 32'b001);
        req_valid = 3'b000;
        m_ready   = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
